// File: rtl/led_btn_ctrl_if.sv
// Button inputs and shifter-control outputs of the LED shifter front end.
// The controller is the slave side; the board or bench drives the master side.
interface led_btn_ctrl_if;
    logic       btn_mode;
    logic       btn_stop;
    logic [1:0] mode;
    logic       stop;
    logic       step;
    logic       mode_chg;

    modport master (
        output btn_mode, btn_stop,
        input  mode, stop, step, mode_chg
    );

    modport slave (
        input  btn_mode, btn_stop,
        output mode, stop, step, mode_chg
    );
endinterface

// File: rtl/led_btn_ctrl.sv
// LED shifter front end: synchronises and debounces two push-buttons,
// cycles the pattern mode, toggles freeze and generates the step tick.
module led_btn_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int TICK_DIV   = 12_500_000,
    parameter int MODE_MAX   = 2
) (
    input  logic          clk,
    input  logic          reset,
    led_btn_ctrl_if.slave bus
);
    localparam int DCW = $clog2(DEB_CYCLES);
    localparam int TCW = $clog2(TICK_DIV);

    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEB_CYCLES - 1);
    localparam logic [DCW-1:0] DCNT_ONE  = DCW'(1);
    localparam logic [TCW-1:0] TCNT_LAST = TCW'(TICK_DIV - 1);
    localparam logic [TCW-1:0] TCNT_ONE  = TCW'(1);
    localparam logic [1:0]     MODE_TOP  = 2'(MODE_MAX);

    // Index 0 is the mode button, index 1 the stop button.
    logic [1:0]          btn_raw;
    logic [1:0]          s1_q, s1_d;
    logic [1:0]          s2_q, s2_d;
    logic [1:0]          deb_q, deb_d;
    logic [1:0]          debp_q, debp_d;
    logic [1:0][DCW-1:0] dcnt_q, dcnt_d;
    logic [1:0]          press;

    logic [1:0]          mode_q, mode_d;
    logic                stop_q, stop_d;
    logic                step_q, step_d;
    logic                mode_chg_q, mode_chg_d;
    logic [TCW-1:0]      tcnt_q, tcnt_d;

    assign btn_raw = {bus.btn_stop, bus.btn_mode};

    always_comb begin
        s1_d   = btn_raw;
        s2_d   = s1_q;
        debp_d = deb_q;
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DCNT_ONE;
                end
            end
        end
    end

    // Only the rising edge of the debounced level acts; releases are ignored.
    assign press = deb_q & ~debp_q;

    always_comb begin
        mode_d     = mode_q;
        stop_d     = stop_q;
        step_d     = 1'b0;
        mode_chg_d = 1'b0;
        tcnt_d     = tcnt_q;

        if (!stop_q) begin
            if (tcnt_q == TCNT_LAST) begin
                tcnt_d = '0;
                step_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TCNT_ONE;
            end
        end

        // A mode change restarts the step phase and suppresses any pending step.
        if (press[0]) begin
            mode_d     = (mode_q == MODE_TOP) ? 2'd0 : mode_q + 2'd1;
            mode_chg_d = 1'b1;
            tcnt_d     = '0;
            step_d     = 1'b0;
        end

        if (press[1]) begin
            stop_d = ~stop_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            debp_q     <= '0;
            dcnt_q     <= '0;
            mode_q     <= '0;
            stop_q     <= 1'b0;
            step_q     <= 1'b0;
            mode_chg_q <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            deb_q      <= deb_d;
            debp_q     <= debp_d;
            dcnt_q     <= dcnt_d;
            mode_q     <= mode_d;
            stop_q     <= stop_d;
            step_q     <= step_d;
            mode_chg_q <= mode_chg_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign bus.mode     = mode_q;
    assign bus.stop     = stop_q;
    assign bus.step     = step_q;
    assign bus.mode_chg = mode_chg_q;
endmodule

// File: tb/tb_led_btn_ctrl.sv
// Directed bench for led_btn_ctrl with short debounce and tick periods.
module tb_led_btn_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   mode_seq [4];
    int   prev_mode;
    int   exp_mode;
    logic exp_step;

    led_btn_ctrl_if bus ();

    led_btn_ctrl #(
        .DEB_CYCLES (4),
        .TICK_DIV   (5),
        .MODE_MAX   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Leaves reset asserted for one sampled edge and checks the reset state.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        check({tag, "_rst_mode"},     32'(bus.mode),     32'd0);
        check({tag, "_rst_stop"},     32'(bus.stop),     32'd0);
        check({tag, "_rst_step"},     32'(bus.step),     32'd0);
        check({tag, "_rst_mode_chg"}, 32'(bus.mode_chg), 32'd0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_stop = 1'b0;
        mode_seq     = '{1, 2, 0, 1};

        // 1: reset then idle, step after edges 5, 10, 15, ...
        do_reset("t1");
        reset = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            check("t1_step", 32'(bus.step), 32'((n % 5) == 0));
            check("t1_mode_chg", 32'(bus.mode_chg), 32'd0);
        end

        // 2: four mode presses, 10 high / 10 low each
        do_reset("t2");
        reset     = 1'b0;
        prev_mode = 0;
        for (int w = 0; w < 4; w++) begin
            for (int c = 1; c <= 20; c++) begin
                bus.btn_mode = (c <= 10);
                tick();
                exp_mode = (c >= 7) ? mode_seq[w] : prev_mode;
                exp_step = (c == 12) || (c == 17) || ((w == 0) ? (c == 5) : (c == 2));
                check("t2_mode", 32'(bus.mode), 32'(exp_mode));
                check("t2_mode_chg", 32'(bus.mode_chg), 32'(c == 7));
                check("t2_step", 32'(bus.step), 32'(exp_step));
            end
            prev_mode = mode_seq[w];
        end

        // 3: glitches 3 high / 1 low / 3 high are rejected
        do_reset("t3");
        reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            bus.btn_mode = (c <= 3) || (c >= 5 && c <= 7);
            tick();
            check("t3_glitch_mode", 32'(bus.mode), 32'd0);
            check("t3_glitch_chg", 32'(bus.mode_chg), 32'd0);
        end
        // then a 6-cycle press gives one increment
        for (int c = 1; c <= 20; c++) begin
            bus.btn_mode = (c <= 6);
            tick();
            check("t3_press_mode", 32'(bus.mode), 32'(c >= 7));
            check("t3_press_chg", 32'(bus.mode_chg), 32'(c == 7));
        end

        // 4: freeze and un-freeze keep the step phase
        do_reset("t4");
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            bus.btn_stop = (c <= 10);
            tick();
            check("t4_freeze_stop", 32'(bus.stop), 32'(c >= 7));
            check("t4_freeze_step", 32'(bus.step), 32'(c == 5));
        end
        for (int c = 1; c <= 20; c++) begin
            bus.btn_stop = (c <= 10);
            tick();
            check("t4_run_stop", 32'(bus.stop), 32'(c < 7));
            check("t4_run_step", 32'(bus.step), 32'((c == 10) || (c == 15) || (c == 20)));
        end

        // 5: both buttons on the same edge
        do_reset("t5");
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            bus.btn_mode = (c <= 10);
            bus.btn_stop = (c <= 10);
            tick();
            check("t5_mode", 32'(bus.mode), 32'(c >= 7));
            check("t5_stop", 32'(bus.stop), 32'(c >= 7));
            check("t5_mode_chg", 32'(bus.mode_chg), 32'(c == 7));
            check("t5_step", 32'(bus.step), 32'(c == 5));
        end

        // 6: reset with mode=2, stop=1 and a debounce count in flight
        for (int c = 1; c <= 20; c++) begin
            bus.btn_mode = (c <= 10);
            tick();
        end
        check("t6_pre_mode", 32'(bus.mode), 32'd2);
        check("t6_pre_stop", 32'(bus.stop), 32'd1);
        bus.btn_mode = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
        end
        do_reset("t6");
        reset = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            check("t6_mode", 32'(bus.mode), 32'(c >= 7));
            check("t6_mode_chg", 32'(bus.mode_chg), 32'(c == 7));
            check("t6_step", 32'(bus.step), 32'((c == 5) || (c == 12)));
        end
        bus.btn_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
